// File: rtl/led_blink_multi.sv
// rtl/led_blink_multi.sv - multi-channel LED driver with OFF/ON/BLINK/PWM modes per channel
// Define LED_BREATHE_EN to make mode 3 a triangle-ramp breathe instead of fixed-duty PWM.
module led_blink_multi #(
  parameter  int N_CH   = 4,
  parameter  int DIV_W  = 24,
  parameter  int DUTY_W = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DIV_W-1:0]  cfg_half,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic [N_CH-1:0]   led
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [DUTY_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pwm_cnt <= '0;
    else        r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    mode_e             r_mode;
    logic [DIV_W-1:0]  r_half;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [DUTY_W-1:0] r_duty_cur;
    logic              r_phase;
    logic              r_led;
    logic              w_wr;
    logic              w_div_on;
    logic              w_step;
    logic              w_led_nxt;
`ifdef LED_BREATHE_EN
    logic              r_dir_up;
`endif

    // Equality with an in-range index also rejects any cfg_ch >= N_CH.
    assign w_wr     = cfg_we && (cfg_ch == CH_W'(g));
    assign w_div_on = (r_mode == MODE_BLINK) || (r_mode == MODE_PWM);
    assign w_step   = w_div_on && (r_div_cnt == r_half);

    always_comb begin
      w_led_nxt = 1'b0;
      case (r_mode)
        MODE_OFF:   w_led_nxt = 1'b0;
        MODE_ON:    w_led_nxt = 1'b1;
        MODE_BLINK: w_led_nxt = r_phase;
        MODE_PWM:   w_led_nxt = (r_pwm_cnt < r_duty_cur);
        default:    w_led_nxt = 1'b0;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mode     <= MODE_OFF;
        r_half     <= '0;
        r_div_cnt  <= '0;
        r_duty_cur <= '0;
        r_phase    <= 1'b0;
        r_led      <= 1'b0;
`ifdef LED_BREATHE_EN
        r_dir_up   <= 1'b1;
`endif
      end else begin
        r_led <= w_led_nxt;
        if (w_wr) begin
          r_mode     <= mode_e'(cfg_mode);
          r_half     <= cfg_half;
          r_duty_cur <= cfg_duty;
          r_div_cnt  <= '0;
          r_phase    <= 1'b0;
`ifdef LED_BREATHE_EN
          r_dir_up   <= 1'b1;
`endif
        end else if (w_div_on) begin
          r_div_cnt <= w_step ? '0 : r_div_cnt + DIV_W'(1);
          if (w_step && (r_mode == MODE_BLINK)) r_phase <= ~r_phase;
`ifdef LED_BREATHE_EN
          // Ramp endpoints are visited once each, then the direction flips.
          if (w_step && (r_mode == MODE_PWM)) begin
            if (r_dir_up) begin
              if (r_duty_cur == '1) begin
                r_duty_cur <= r_duty_cur - DUTY_W'(1);
                r_dir_up   <= 1'b0;
              end else begin
                r_duty_cur <= r_duty_cur + DUTY_W'(1);
              end
            end else begin
              if (r_duty_cur == '0) begin
                r_duty_cur <= DUTY_W'(1);
                r_dir_up   <= 1'b1;
              end else begin
                r_duty_cur <= r_duty_cur - DUTY_W'(1);
              end
            end
          end
`endif
        end else begin
          r_div_cnt <= '0;
          r_phase   <= 1'b0;
        end
      end
    end

    assign led[g] = r_led;
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// tb/tb_led_blink_multi.sv - randomized bench for led_blink_multi against an arithmetic reference model
// Honours LED_BREATHE_EN in the model when the design is built with it.
module tb_led_blink_multi;

  localparam int N_CH   = 5;
  localparam int DIV_W  = 24;
  localparam int DUTY_W = 8;
  localparam int CH_W   = 3;
  localparam int PWM_P  = 1 << DUTY_W;
  localparam int DMAX   = PWM_P - 1;

  logic              clk;
  logic              rst_n;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [1:0]        cfg_mode;
  logic [DIV_W-1:0]  cfg_half;
  logic [DUTY_W-1:0] cfg_duty;
  logic [N_CH-1:0]   led;

  led_blink_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .DUTY_W(DUTY_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_half (cfg_half),
    .cfg_duty (cfg_duty),
    .led      (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: per-channel config plus the edge index of its last write; e counts edges since reset release.
  int e;
  int m_mode [N_CH];
  int m_half [N_CH];
  int m_duty [N_CH];
  int m_w    [N_CH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, e, $time);
    end
  endtask

  function automatic int tri_duty(input int d, input int s);
    int t;
    t = (d + s) % (2 * DMAX);
    return (t <= DMAX) ? t : (2 * DMAX - t);
  endfunction

  function automatic logic [N_CH-1:0] model_led();
    logic [N_CH-1:0] v;
    int dc;
    v = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (m_mode[i])
        1: v[i] = 1'b1;
        2: v[i] = (((e - m_w[i] - 1) / (m_half[i] + 1)) % 2) == 1;
        3: begin
`ifdef LED_BREATHE_EN
          dc = tri_duty(m_duty[i], (e - 1 - m_w[i]) / (m_half[i] + 1));
`else
          dc = m_duty[i];
`endif
          v[i] = ((e - 1) % PWM_P) < dc;
        end
        default: v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic model_reset();
    e = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_mode[i] = 0; m_half[i] = 0; m_duty[i] = 0; m_w[i] = 0;
    end
  endtask

  // Called at a negedge; drives inputs, takes one posedge, checks led, returns at the next negedge.
  task automatic cyc(input logic we, input int ch, input int mode, input int half, input int duty);
    logic [N_CH-1:0] exp;
    cfg_we   = we;
    cfg_ch   = CH_W'(ch);
    cfg_mode = 2'(mode);
    cfg_half = DIV_W'(half);
    cfg_duty = DUTY_W'(duty);
    @(posedge clk);
    e++;
    exp = model_led();
    if (we && ch < N_CH) begin
      m_mode[ch] = mode; m_half[ch] = half; m_duty[ch] = duty; m_w[ch] = e;
    end
    #1;
    check_eq("led", 32'(led), 32'(exp));
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 0, 0, 0);
  endtask

  int hi_cnt;

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_duty = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_eq("reset_led", 32'(led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in the middle of a blink period.
    cyc(1'b1, 0, 2, 3, 0);
    idle(9);
    #2 rst_n = 1'b0;
    #1 check_eq("async_rst_led", 32'(led), 32'd0);
    model_reset();
    @(posedge clk);
    #1 check_eq("rst_held_led", 32'(led), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(12);

    // Blink H=3 on ch1: 4 low, 4 high.
    cyc(1'b1, 1, 2, 3, 0);
    idle(20);

    // PWM duty 64 on ch2: exactly 64 highs per 256 edges.
    cyc(1'b1, 2, 3, 0, 64);
    hi_cnt = 0;
    for (int i = 0; i < PWM_P; i++) begin
      cyc(1'b0, 0, 0, 0, 0);
      hi_cnt += int'(led[2]);
    end
`ifndef LED_BREATHE_EN
    check_eq("pwm64_high_count", 32'(hi_cnt), 32'd64);
`endif
    cyc(1'b1, 2, 3, 0, 0);
    hi_cnt = 0;
    for (int i = 0; i < PWM_P; i++) begin
      cyc(1'b0, 0, 0, 0, 0);
      hi_cnt += int'(led[2]);
    end
`ifndef LED_BREATHE_EN
    check_eq("pwm0_high_count", 32'(hi_cnt), 32'd0);
`endif
    cyc(1'b1, 2, 0, 0, 0);

    // ch3 ON, then out-of-range channel write must change nothing.
    cyc(1'b1, 3, 1, 0, 0);
    cyc(1'b1, 5, 0, 0, 0);
    cyc(1'b1, 7, 0, 0, 0);
    idle(5);
    check_eq("ch3_on_kept", 32'(led[3]), 32'd1);

    // Rewrite ch1 mid-period with H=1.
    idle(2);
    cyc(1'b1, 1, 2, 1, 0);
    idle(12);

    // PWM extremes.
    cyc(1'b1, 4, 3, 0, DMAX);
    idle(300);

`ifdef LED_BREATHE_EN
    // Breathe from 254 with a step every edge, through both turnarounds.
    cyc(1'b1, 0, 3, 0, 254);
    idle(800);
`endif

    // Randomized config traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        cyc(1'b1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, DMAX));
      else
        cyc(1'b0, 0, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
